// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for regfile_sb: read ports, write port, destination
// reservation and scoreboard status.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  // Handshakes: wr_en is a valid with no ready (a write is always accepted);
  // rsv_en is a valid whose ready is !rsv_full, so a reservation takes effect
  // only on an edge where rsv_en=1 and rsv_full=0, and decode holds it otherwise.
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_full;
  logic                     flush;
  logic                     err_underflow;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, rsv_full, err_underflow
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, rsv_full, err_underflow
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with write-to-read bypass, hardwired zero register and a
// per-register pending-write counter used by decode for RAW hazard detection.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs    [DEPTH];
  logic [CNT_W-1:0]  cnt     [DEPTH];
  logic [CNT_W-1:0]  cnt_nxt [DEPTH];
  logic              inc_v   [DEPTH];
  logic              dec_v   [DEPTH];
  logic [ADDR_W-1:0] ra      [NUM_RD];
  logic              err_q;
  logic              underflow;
  logic              full_c;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_ra
    assign ra[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
  end

  // Conservative: a same-cycle retire on rsv_addr does not lift the refusal.
  assign full_c = rst_n && bus.rsv_en && (bus.rsv_addr != '0) &&
                  (cnt[bus.rsv_addr] == CNT_MAX);

  always_comb begin
    underflow = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      inc_v[r]   = bus.rsv_en && (bus.rsv_addr == ADDR_W'(r)) && (r != 0) && !full_c;
      dec_v[r]   = bus.wr_en && (bus.wr_addr == ADDR_W'(r)) && (r != 0);
      cnt_nxt[r] = cnt[r];
      if (bus.flush) begin
        cnt_nxt[r] = '0;
      end else if (inc_v[r] && !dec_v[r]) begin
        cnt_nxt[r] = cnt[r] + CNT_W'(1);
      end else if (dec_v[r] && !inc_v[r]) begin
        if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - CNT_W'(1);
        else              underflow  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (bus.wr_en && (bus.wr_addr != '0)) regs[bus.wr_addr] <= bus.wr_data;
      for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
      if (underflow) err_q <= 1'b1;
    end
  end

  // Outputs are gated by rst_n so the bypass cannot leak wr_data during reset.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst_n && (ra[i] != '0)) begin
        if (bus.wr_en && (bus.wr_addr == ra[i])) bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
        else                                     bus.rd_data[i*DATA_W +: DATA_W] = regs[ra[i]];
        bus.rd_busy[i] = (cnt[ra[i]] != '0) &&
                         !(bus.wr_en && (bus.wr_addr == ra[i]) && (cnt[ra[i]] == CNT_W'(1)));
      end
    end
  end

  assign bus.rsv_full      = full_c;
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a spec-level model checked every cycle plus
// hand-computed expectations at the scenario points.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;
  localparam int CMAX   = 3;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [DATA_W-1:0] mreg [DEPTH];
  int                mcnt [DEPTH];
  bit                merr;
  logic [DATA_W-1:0] exp_q [$];

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (!rst_n || a == 0) return '0;
    if (bus.wr_en && int'(bus.wr_addr) == a) return bus.wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!rst_n || a == 0 || mcnt[a] == 0) return 1'b0;
    return !(bus.wr_en && int'(bus.wr_addr) == a && mcnt[a] == 1);
  endfunction

  function automatic logic exp_full();
    return rst_n && bus.rsv_en && bus.rsv_addr != 0 && mcnt[bus.rsv_addr] == CMAX;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mreg[r] = '0;
        mcnt[r] = 0;
      end
      merr = 1'b0;
    end else begin
      bit full;
      full = exp_full();
      if (bus.flush) begin
        for (int r = 0; r < DEPTH; r++) mcnt[r] = 0;
      end else begin
        for (int r = 1; r < DEPTH; r++) begin
          bit inc, dec;
          inc = bus.rsv_en && int'(bus.rsv_addr) == r && !full;
          dec = bus.wr_en && int'(bus.wr_addr) == r;
          if (inc && !dec) mcnt[r] = mcnt[r] + 1;
          else if (dec && !inc) begin
            if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
            else             merr = 1'b1;
          end
        end
      end
      if (bus.wr_en && bus.wr_addr != 0) mreg[bus.wr_addr] = bus.wr_data;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NUM_RD; i++) exp_q.push_back(exp_data(int'(bus.rd_addr[i*ADDR_W +: ADDR_W])));
    for (int i = 0; i < NUM_RD; i++) begin
      logic [DATA_W-1:0] e;
      e = exp_q.pop_front();
      chk($sformatf("model rd_data%0d", i), bus.rd_data[i*DATA_W +: DATA_W], e);
      chk($sformatf("model rd_busy%0d", i), DATA_W'(bus.rd_busy[i]),
          DATA_W'(exp_busy(int'(bus.rd_addr[i*ADDR_W +: ADDR_W]))));
    end
    chk("model rsv_full", DATA_W'(bus.rsv_full), DATA_W'(exp_full()));
    chk("model err_underflow", DATA_W'(bus.err_underflow), DATA_W'(merr));
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input int a0, input int a1);
    bus.rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = d;
  endtask

  task automatic rsv(input int a);
    bus.rsv_en = 1'b1; bus.rsv_addr = ADDR_W'(a);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, a);
      settle();
      if (a == 31) begin
        chk("reset rd_data", bus.rd_data[31:0], 32'h0);
        chk("reset rd_busy", DATA_W'(bus.rd_busy), 32'h0);
        chk("reset err", DATA_W'(bus.err_underflow), 32'h0);
      end
    end
    tick();
    rst_n = 1'b1;
    idle();
    tick();

    // write r5 with same-cycle bypass, then registered read
    wr(5, 32'hDEADBEEF); rd(5, 0);
    settle(); chk("bypass r5", bus.rd_data[31:0], 32'hDEADBEEF);
    tick(); bus.wr_en = 1'b0;
    settle(); chk("stored r5", bus.rd_data[31:0], 32'hDEADBEEF);
    tick(); wr(0, 32'h1234); rd(0, 0);
    settle(); chk("r0 bypass blocked", bus.rd_data[31:0], 32'h0);
    tick(); bus.wr_en = 1'b0;
    settle(); chk("r0 stays zero", bus.rd_data[63:32], 32'h0);

    // reserve r7, retire it with a bypassed write
    tick(); rsv(7); rd(7, 7);
    settle(); chk("r7 not busy at rsv", DATA_W'(bus.rd_busy), 32'h0);
    tick(); bus.rsv_en = 1'b0;
    settle(); chk("r7 busy after rsv", DATA_W'(bus.rd_busy), 32'h3);
    tick();
    tick(); wr(7, 32'h55);
    settle();
    chk("r7 retire busy", DATA_W'(bus.rd_busy), 32'h0);
    chk("r7 retire data", bus.rd_data[31:0], 32'h55);
    tick(); bus.wr_en = 1'b0;
    settle(); chk("r7 idle after retire", DATA_W'(bus.rd_busy), 32'h0);

    // fill r9 to the counter maximum
    for (int k = 0; k < 3; k++) begin
      tick(); rsv(9);
    end
    tick();
    settle(); chk("r9 rsv_full", DATA_W'(bus.rsv_full), 32'h1);
    tick(); bus.rsv_en = 1'b0; rd(9, 9);
    for (int k = 1; k <= 3; k++) begin
      wr(9, DATA_W'(k));
      settle();
      chk($sformatf("r9 busy on write %0d", k), DATA_W'(bus.rd_busy), (k < 3) ? 32'h3 : 32'h0);
      tick();
    end
    bus.wr_en = 1'b0;
    settle();
    chk("r9 idle", DATA_W'(bus.rd_busy), 32'h0);
    chk("r9 data", bus.rd_data[63:32], 32'h3);

    // simultaneous reserve + write, then flush beats a reservation
    tick(); rsv(3); rd(3, 3);
    tick(); wr(3, 32'hA5);
    settle(); chk("r3 inc+dec bypass", DATA_W'(bus.rd_busy), 32'h0);
    tick(); idle(); rd(3, 3);
    settle(); chk("r3 still pending", DATA_W'(bus.rd_busy), 32'h3);
    tick(); bus.flush = 1'b1; rsv(4); rd(4, 3);
    tick(); idle(); rd(4, 3);
    settle(); chk("flush clears", DATA_W'(bus.rd_busy), 32'h0);

    // underflow is sticky across flush
    tick(); wr(12, 32'h77);
    tick(); idle();
    settle(); chk("underflow set", DATA_W'(bus.err_underflow), 32'h1);
    tick(); bus.flush = 1'b1;
    tick(); bus.flush = 1'b0;
    settle(); chk("underflow survives flush", DATA_W'(bus.err_underflow), 32'h1);

    // mixed traffic on a few addresses, checked by the model each cycle
    for (int n = 0; n < 60; n++) begin
      tick();
      rd($urandom_range(0, 3), $urandom_range(0, 3));
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_addr  = ADDR_W'($urandom_range(0, 3));
      bus.wr_data  = $urandom;
      bus.rsv_en   = 1'($urandom_range(0, 1));
      bus.rsv_addr = ADDR_W'($urandom_range(0, 3));
      bus.flush    = ($urandom_range(0, 9) == 0);
    end

    // asynchronous reset mid-traffic
    tick(); idle(); rsv(7);
    tick(); bus.rsv_en = 1'b0; wr(5, 32'hABC); rd(5, 7);
    settle();
    chk("pre-reset bypass", bus.rd_data[31:0], 32'hABC);
    chk("pre-reset busy", DATA_W'(bus.rd_busy[1]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async reset rd_data", bus.rd_data, '0);
    chk("async reset rd_busy", DATA_W'(bus.rd_busy), 32'h0);
    chk("async reset err", DATA_W'(bus.err_underflow), 32'h0);
    tick();
    idle();
    tick(); rst_n = 1'b1;
    tick();
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, clocked register file with a per-register in-flight scoreboard. It replaces the combinational single-write register array in the MIPS pipeline.
- Provides NUM_RD combinational read ports with write-to-read bypass, one synchronous write port and a hardwired zero register.
- Keeps a per-register pending-write counter so the decode stage can detect RAW hazards directly.
- Sits between decode (reads, busy checks, destination reservation) and writeback (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- CNT_W, 2, pending counter width per register; max in-flight = 2^CNT_W-1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i is at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr
- rd_busy  out  NUM_RD  port i's register has an outstanding write not satisfied by bypass this cycle
- wr_en  in  1  writeback valid
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- rsv_en  in  1  reserve destination (instruction issued)
- rsv_addr  in  ADDR_W  destination being reserved
- rsv_full  out  1  rsv_addr's counter is at max; the reservation is refused
- flush  in  1  clear all pending counters (pipeline squash)
- err_underflow  out  1  sticky flag: a write arrived for a register whose counter was 0

## Operation
- Storage: REG[0..2^ADDR_W-1] of DATA_W bits; CNT[0..2^ADDR_W-1] of CNT_W bits.
- Reset (rst_n low, asynchronous):
  - All REG and CNT entries cleared to 0; err_underflow cleared to 0.
  - Outputs while in reset: rd_data = 0, rd_busy = 0, rsv_full = 0.
- Write: on a clk edge with wr_en=1 and wr_addr!=0, REG[wr_addr] <= wr_data. Writes to address 0 are dropped.
- Read, per port i (combinational), with a = rd_addr[i]:
  - a==0: rd_data = 0.
  - Else if wr_en and wr_addr==a: rd_data = wr_data (bypass).
  - Else: rd_data = REG[a].
- Busy, per port i:
  - rd_busy = (a!=0) and CNT[a]!=0 and not (wr_en and wr_addr==a and CNT[a]==1).
  - A write retiring the last pending producer is therefore consumable through the bypass in the same cycle.
- Counter update per register r on each clk edge, with inc = rsv_en and rsv_addr==r and r!=0 and not rsv_full, and dec = wr_en and wr_addr==r and r!=0:
  - flush=1: CNT[r] <= 0 for every r. flush takes priority over inc and dec.
  - inc and dec: unchanged.
  - inc only: +1.
  - dec only with CNT[r]>0: -1.
  - dec only with CNT[r]==0: unchanged, and err_underflow <= 1.
- rsv_full = rsv_en and rsv_addr!=0 and CNT[rsv_addr]==2^CNT_W-1.
  - rsv_full is combinational. Decode must stall; a refused reservation has no effect.
  - A same-cycle dec on that register does not lift rsv_full. The check is conservative.
- err_underflow clears only on reset. It is not cleared by flush.
- Address 0: never busy, never counted, never written. rsv_en to address 0 is a no-op.
- Simultaneous events:
  - A read of wr_addr during a write returns wr_data.
  - Any number of read ports may use the same address.
  - rsv_addr==wr_addr in the same cycle is covered by the inc/dec rule.
- Reset mid-operation: all pending state is lost immediately, with no clock needed. The pipeline must be flushed alongside it.

## Timing
- Read and bypass path: 0-cycle latency, purely combinational from rd_addr, wr_en, wr_addr and wr_data.
- Write: visible through REG on the cycle after the edge, and through bypass in the same cycle.
- Counter: a reservation at edge N makes rd_busy=1 from cycle N+1. The matching write in cycle M makes rd_busy=0 in cycle M (when CNT was 1).
- rsv_full and rd_busy: combinational from registered CNT plus current-cycle inputs.
- err_underflow: set on the edge that saw the underflow, visible the following cycle.

## Test plan
- Reset, then read all addresses on every port -> rd_data=0, rd_busy=0, err_underflow=0. Assert rst_n low mid-traffic -> same values without a clock edge.
- Write REG[5]=0xDEADBEEF while port0 reads 5 -> rd_data0=0xDEADBEEF in the same cycle. Next cycle, with wr_en=0 -> still 0xDEADBEEF. Write 0x1234 to address 0 -> reading 0 returns 0.
- Reserve r7 at edge 1 -> rd_busy=1 for a port reading 7 from cycle 2. Write r7=0x55 in cycle 4 -> rd_busy=0 and rd_data=0x55 in cycle 4. CNT[7]=0 after the edge.
- Reserve r9 three times with CNT_W=2 -> fourth rsv_en gives rsv_full=1 and CNT stays 3. Three writes to r9 -> rd_busy stays 1 through the second write, drops on the third.
- Reserve and write r3 in the same cycle with CNT[3]=1 -> CNT stays 1, rd_busy still 1. Assert flush with rsv_en to r4 -> all CNT=0, r4 not busy next cycle.
- Write r12 with CNT[12]=0 -> err_underflow=1 next cycle and stays high across flush. Reset clears it.
